// File: rtl/rr_mux_arbiter_if.sv
// Requester/consumer bundle for the round-robin mux arbiter.
// The arbiter attaches through the slave modport; the requester and
// consumer side (or a testbench) attaches through the master modport.
interface rr_mux_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int SEL_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        i_req;
    logic [N_REQ*DATA_W-1:0] i_data;
    logic [N_REQ-1:0]        i_last;
    logic                    i_ready;
    logic [N_REQ-1:0]        o_ack;
    logic                    o_valid;
    logic [DATA_W-1:0]       o_data;
    logic                    o_last;
    logic [SEL_W-1:0]        o_sel;
    logic                    o_busy;

    modport slave (
        input  i_req, i_data, i_last, i_ready,
        output o_ack, o_valid, o_data, o_last, o_sel, o_busy
    );

    modport master (
        output i_req, i_data, i_last, i_ready,
        input  o_ack, o_valid, o_data, o_last, o_sel, o_busy
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin packet arbiter driving a shared mux toward one consumer.
// A grant is held until the owner's last beat or until MAX_BURST beats
// have been accepted; on release the next winner is chosen in the same
// cycle so consecutive packets flow without a bubble.
module rr_mux_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    rr_mux_arbiter_if.slave   bus
);
    localparam int SEL_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy;
    logic [SEL_W-1:0] owner_inc;
    logic [SEL_W-1:0] arb_start;
    logic [SEL_W:0]   rot_sum [N_REQ];
    logic [SEL_W-1:0] rot_idx [N_REQ];
    logic [N_REQ-1:0] rot_hit;
    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [DATA_W-1:0] data_arr [N_REQ];
    logic             cur_req;
    logic             cur_last;
    logic             xfer;
    logic             pkt_release;
    logic [N_REQ-1:0] ack;

    assign busy      = (state_q == ST_BUSY);
    assign owner_inc = (owner_q == SEL_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // While busy the only arbitration that matters happens on release,
    // and it starts just past the current owner (the new ptr value).
    assign arb_start = busy ? owner_inc : ptr_q;

    // Rotate the request vector so position gi is priority rank gi.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot_sum[gi] = {1'b0, arb_start} + (SEL_W + 1)'(gi);
            assign rot_idx[gi] = (rot_sum[gi] >= (SEL_W + 1)'(N_REQ))
                               ? SEL_W'(rot_sum[gi] - (SEL_W + 1)'(N_REQ))
                               : rot_sum[gi][SEL_W-1:0];
            assign rot_hit[gi]  = bus.i_req[rot_idx[gi]];
            assign data_arr[gi] = bus.i_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Pick the lowest-rank requester; scanning downward leaves the first hit.
    always_comb begin
        win_found = |rot_hit;
        win_idx   = rot_idx[0];
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_hit[i]) begin
                win_idx = rot_idx[i];
            end
        end
    end

    assign cur_req     = bus.i_req[owner_q];
    assign cur_last    = bus.i_last[owner_q];
    assign xfer        = busy && cur_req && bus.i_ready;
    assign pkt_release = xfer && (cur_last || (cnt_q == CNT_W'(MAX_BURST - 1)));

    // Acknowledge only the owner, and only on an accepted beat.
    always_comb begin
        ack          = '0;
        ack[owner_q] = xfer;
    end

    assign bus.o_ack   = ack;
    assign bus.o_valid = busy && cur_req;
    assign bus.o_data  = data_arr[owner_q];
    assign bus.o_last  = busy && cur_last;
    assign bus.o_sel   = owner_q;
    assign bus.o_busy  = busy;

    // Grant/release decisions and beat counting for the next cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (!busy) begin
            if (win_found) begin
                owner_d = win_idx;
                cnt_d   = '0;
                state_d = ST_BUSY;
            end
        end else if (xfer) begin
            cnt_d = cnt_q + 1'b1;
            if (pkt_release) begin
                ptr_d = owner_inc;
                if (win_found) begin
                    owner_d = win_idx;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed table-driven bench for rr_mux_arbiter (N_REQ=4, DATA_W=8, MAX_BURST=4).
module tb_rr_mux_arbiter;
    logic clk;
    logic rst_n;

    rr_mux_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

    rr_mux_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  last;
        logic        ready;
        logic        exp_busy;
        logic [1:0]  exp_sel;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_last;
        logic [3:0]  exp_ack;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_errors;

    function automatic vec_t mk(logic r, logic [3:0] q, logic [31:0] d, logic [3:0] l,
                                logic rd, logic eb, logic [1:0] es, logic ev,
                                logic [7:0] ed, logic el, logic [3:0] ea);
        vec_t v;
        v.do_rst = r;   v.req = q;      v.data = d;      v.last = l;  v.ready = rd;
        v.exp_busy = eb; v.exp_sel = es; v.exp_valid = ev; v.exp_data = ed;
        v.exp_last = el; v.exp_ack = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " busy"},  32'(bus.o_busy),  32'(v.exp_busy));
        check({tag, " sel"},   32'(bus.o_sel),   32'(v.exp_sel));
        check({tag, " valid"}, 32'(bus.o_valid), 32'(v.exp_valid));
        check({tag, " last"},  32'(bus.o_last),  32'(v.exp_last));
        check({tag, " ack"},   32'(bus.o_ack),   32'(v.exp_ack));
        if (v.exp_valid) begin
            check({tag, " data"}, 32'(bus.o_data), 32'(v.exp_data));
        end
    endtask

    initial begin
        vec_t h;
        n_checks = 0;
        n_errors = 0;
        rst_n       = 1'b0;
        bus.i_req   = '0;
        bus.i_data  = '0;
        bus.i_last  = '0;
        bus.i_ready = 1'b0;

        // Single requester 2, 3-beat packet; requester 3 appears on the last
        // beat to show the pointer moved past 2 (start at 3 picks 3, not 2).
        vecs.push_back(mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 0, 0, 8'h00, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0100, 32'h00A1_0000, 4'b0000, 1, 0, 0, 0, 8'h00, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0100, 32'h00A1_0000, 4'b0000, 1, 1, 2, 1, 8'hA1, 0, 4'b0100));
        vecs.push_back(mk(0, 4'b0100, 32'h00A2_0000, 4'b0000, 1, 1, 2, 1, 8'hA2, 0, 4'b0100));
        vecs.push_back(mk(0, 4'b1100, 32'h33A3_0000, 4'b0100, 1, 1, 2, 1, 8'hA3, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b1000, 32'h3300_0000, 4'b1000, 1, 1, 3, 1, 8'h33, 1, 4'b1000));
        // All four requesting 1-beat packets: 0,1,2,3,0 back to back.
        vecs.push_back(mk(1, 4'b1111, 32'hB3B2_B1B0, 4'b1111, 1, 0, 0, 0, 8'h00, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 32'hB3B2_B1B0, 4'b1111, 1, 1, 0, 1, 8'hB0, 1, 4'b0001));
        vecs.push_back(mk(0, 4'b1111, 32'hB3B2_B1B0, 4'b1111, 1, 1, 1, 1, 8'hB1, 1, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 32'hB3B2_B1B0, 4'b1111, 1, 1, 2, 1, 8'hB2, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b1111, 32'hB3B2_B1B0, 4'b1111, 1, 1, 3, 1, 8'hB3, 1, 4'b1000));
        vecs.push_back(mk(0, 4'b1111, 32'hB3B2_B1B0, 4'b1111, 1, 1, 0, 1, 8'hB0, 1, 4'b0001));
        // Burst cap: requester 1 six beats, requester 3 one beat.
        vecs.push_back(mk(1, 4'b1010, 32'hD100_C100, 4'b1000, 1, 0, 0, 0, 8'h00, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1010, 32'hD100_C100, 4'b1000, 1, 1, 1, 1, 8'hC1, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b1010, 32'hD100_C200, 4'b1000, 1, 1, 1, 1, 8'hC2, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b1010, 32'hD100_C300, 4'b1000, 1, 1, 1, 1, 8'hC3, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b1010, 32'hD100_C400, 4'b1000, 1, 1, 1, 1, 8'hC4, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b1010, 32'hD100_C500, 4'b1000, 1, 1, 3, 1, 8'hD1, 1, 4'b1000));
        vecs.push_back(mk(0, 4'b0010, 32'h0000_C500, 4'b0000, 1, 1, 1, 1, 8'hC5, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0010, 32'h0000_C600, 4'b0010, 1, 1, 1, 1, 8'hC6, 1, 4'b0010));
        // Backpressure for 3 cycles on the first beat; the cap must still
        // allow four accepted beats before requester 2 gets its turn.
        vecs.push_back(mk(1, 4'b0101, 32'h00F1_00E1, 4'b0100, 0, 0, 0, 0, 8'h00, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0101, 32'h00F1_00E1, 4'b0100, 0, 1, 0, 1, 8'hE1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0101, 32'h00F1_00E1, 4'b0100, 0, 1, 0, 1, 8'hE1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0101, 32'h00F1_00E1, 4'b0100, 0, 1, 0, 1, 8'hE1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0101, 32'h00F1_00E1, 4'b0100, 1, 1, 0, 1, 8'hE1, 0, 4'b0001));
        vecs.push_back(mk(0, 4'b0101, 32'h00F1_00E2, 4'b0100, 1, 1, 0, 1, 8'hE2, 0, 4'b0001));
        vecs.push_back(mk(0, 4'b0101, 32'h00F1_00E3, 4'b0100, 1, 1, 0, 1, 8'hE3, 0, 4'b0001));
        vecs.push_back(mk(0, 4'b0101, 32'h00F1_00E4, 4'b0100, 1, 1, 0, 1, 8'hE4, 0, 4'b0001));
        vecs.push_back(mk(0, 4'b0101, 32'h00F1_00E5, 4'b0100, 1, 1, 2, 1, 8'hF1, 1, 4'b0100));
        // Owner 2 stalls for 2 cycles while requester 0 waits.
        vecs.push_back(mk(1, 4'b0100, 32'h0061_0000, 4'b0000, 1, 0, 0, 0, 8'h00, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0100, 32'h0061_0000, 4'b0000, 1, 1, 2, 1, 8'h61, 0, 4'b0100));
        vecs.push_back(mk(0, 4'b0001, 32'h0000_0071, 4'b0001, 1, 1, 2, 0, 8'h00, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0001, 32'h0000_0071, 4'b0001, 1, 1, 2, 0, 8'h00, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0101, 32'h0062_0071, 4'b0101, 1, 1, 2, 1, 8'h62, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b0001, 32'h0000_0071, 4'b0001, 1, 1, 0, 1, 8'h71, 1, 4'b0001));

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].do_rst) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            bus.i_req   = vecs[v].req;
            bus.i_data  = vecs[v].data;
            bus.i_last  = vecs[v].last;
            bus.i_ready = vecs[v].ready;
            #2;
            check_outputs($sformatf("vec%0d", v), vecs[v]);
            $display("vec %0d: req=%b rdy=%b busy=%b sel=%0d valid=%b data=%h last=%b ack=%b",
                     v, bus.i_req, bus.i_ready, bus.o_busy, bus.o_sel, bus.o_valid,
                     bus.o_data, bus.o_last, bus.o_ack);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a held packet.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.i_req   = 4'b0100;
        bus.i_data  = 32'h0055_0000;
        bus.i_last  = 4'b0100;
        bus.i_ready = 1'b0;
        @(posedge clk);
        #1;
        h = mk(0, 4'b0100, 32'h0055_0000, 4'b0100, 0, 1, 2, 1, 8'h55, 1, 4'b0000);
        check_outputs("arst_pre", h);
        $display("arst pre: busy=%b sel=%0d valid=%b", bus.o_busy, bus.o_sel, bus.o_valid);
        #2;
        rst_n = 1'b0;
        #1;
        h = mk(0, 4'b0100, 32'h0055_0000, 4'b0100, 0, 0, 0, 0, 8'h00, 0, 4'b0000);
        check_outputs("arst_now", h);
        $display("arst now: busy=%b sel=%0d valid=%b last=%b", bus.o_busy, bus.o_sel, bus.o_valid, bus.o_last);
        @(posedge clk);
        #1;
        check_outputs("arst_hold", h);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        h = mk(0, 4'b0100, 32'h0055_0000, 4'b0100, 0, 1, 2, 1, 8'h55, 1, 4'b0000);
        check_outputs("arst_post", h);
        $display("arst post: busy=%b sel=%0d valid=%b", bus.o_busy, bus.o_sel, bus.o_valid);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
